// File: rtl/median_window_ctrl_if.sv
// Pixel-path bundle between the median window sequencer and its neighbours.
//   in_valid/in_sof/in_pix/in_ready : raster input stream
//   p0..p8 / med_in                 : window taps out, median result back
//   out_valid/out_pix/out_sof/out_eof : filtered raster output stream
// The slave modport is the sequencer; the master modport is everything around it.
interface median_window_ctrl_if #(
    parameter int bit_width = 8
);
    logic                 in_valid;
    logic                 in_sof;
    logic [bit_width-1:0] in_pix;
    logic                 in_ready;
    logic [bit_width-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [bit_width-1:0] med_in;
    logic                 out_valid;
    logic [bit_width-1:0] out_pix;
    logic                 out_sof;
    logic                 out_eof;

    modport master (
        output in_valid, in_sof, in_pix, med_in,
        input  in_ready, p0, p1, p2, p3, p4, p5, p6, p7, p8,
        input  out_valid, out_pix, out_sof, out_eof
    );

    modport slave (
        input  in_valid, in_sof, in_pix, med_in,
        output in_ready, p0, p1, p2, p3, p4, p5, p6, p7, p8,
        output out_valid, out_pix, out_sof, out_eof
    );
endinterface

// File: rtl/median_window_ctrl.sv
// 3x3 median filter sequencer: two line buffers feed a 3x3 window whose taps
// go to an external combinational median block; the result (or the centre tap
// on frame-edge pixels) is registered back into a raster output stream.
// An end-of-frame flush pushes IMG_W+1 zero beats so every input pixel gets
// an output.
// Ports: clk, rst (async, active high), bus (median_window_ctrl_if.slave).
//
// state | meaning
// IDLE  | waiting for a beat with in_sof; other beats are dropped
// FILL  | accepting indices 1..IMG_W, window not yet centred, no output
// RUN   | every accepted beat yields one output
// FLUSH | in_ready low, injecting IMG_W+1 zero beats that each yield an output
module median_window_ctrl #(
    parameter int bit_width = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480
) (
    input logic              clk,
    input logic              rst,
    median_window_ctrl_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t               state;
    logic                 in_ready_q;
    logic [CW-1:0]        in_col;
    logic [RW-1:0]        in_row;
    logic [CW-1:0]        ocol;
    logic [RW-1:0]        orow;
    logic [FW-1:0]        flush_cnt;

    // stage A: the accepted (or injected) beat
    logic                 a_valid, a_emit, a_border, a_sof, a_eof;
    logic [CW-1:0]        a_col;
    logic [bit_width-1:0] a_pix;
    // stage B: window taps and the flags of the output they belong to
    logic                 b_emit, b_border, b_sof, b_eof;
    logic [bit_width-1:0] win [9];

    logic [bit_width-1:0] lb1 [IMG_W];
    logic [bit_width-1:0] lb2 [IMG_W];

    logic                 accept, go, emit, restart;
    logic [bit_width-1:0] beat_pix;
    logic                 col_last, row_last;
    logic                 o_border, o_sof, o_eof;

    assign accept   = bus.in_valid & in_ready_q;
    assign col_last = (in_col == CW'(IMG_W - 1));
    assign row_last = (in_row == RW'(IMG_H - 1));
    assign o_border = (orow == '0) | (orow == RW'(IMG_H - 1)) |
                      (ocol == '0) | (ocol == CW'(IMG_W - 1));
    assign o_sof    = (ocol == '0) & (orow == '0);
    assign o_eof    = (ocol == CW'(IMG_W - 1)) & (orow == RW'(IMG_H - 1));

    always_comb begin
        go       = 1'b0;
        emit     = 1'b0;
        restart  = 1'b0;
        beat_pix = bus.in_pix;
        case (state)
            IDLE: begin
                if (accept && bus.in_sof) begin
                    go      = 1'b1;
                    restart = 1'b1;
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    go = 1'b1;
                    if (bus.in_sof) restart = 1'b1;
                    else            emit    = (state == RUN);
                end
            end
            FLUSH: begin
                go       = 1'b1;
                emit     = 1'b1;
                beat_pix = '0;
            end
            default: ;
        endcase
    end

    // Control FSM, counters and stage A. Output position (ocol/orow) is fixed
    // here and carried down the pipe, so an abort can reset the counters while
    // beats already in flight keep their own border/sof/eof flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            in_col     <= '0;
            in_row     <= '0;
            ocol       <= '0;
            orow       <= '0;
            flush_cnt  <= '0;
            a_valid    <= 1'b0;
            a_emit     <= 1'b0;
            a_border   <= 1'b0;
            a_sof      <= 1'b0;
            a_eof      <= 1'b0;
            a_col      <= '0;
            a_pix      <= '0;
        end else begin
            a_valid  <= go;
            a_emit   <= emit;
            a_pix    <= beat_pix;
            a_col    <= restart ? '0 : in_col;
            a_border <= o_border;
            a_sof    <= emit & o_sof;
            a_eof    <= emit & o_eof;

            if (restart) begin
                in_col <= CW'(1);
                in_row <= '0;
                ocol   <= '0;
                orow   <= '0;
            end else if (go) begin
                in_col <= col_last ? '0 : in_col + CW'(1);
                if (col_last) in_row <= row_last ? '0 : in_row + RW'(1);
            end

            if (emit) begin
                if (ocol == CW'(IMG_W - 1)) begin
                    ocol <= '0;
                    orow <= (orow == RW'(IMG_H - 1)) ? '0 : orow + RW'(1);
                end else begin
                    ocol <= ocol + CW'(1);
                end
            end

            case (state)
                IDLE: if (restart) state <= FILL;
                FILL: begin
                    // index IMG_W is the first pixel of row 1
                    if (accept && !restart && in_row == RW'(1) && in_col == '0)
                        state <= RUN;
                end
                RUN: begin
                    if (restart) begin
                        state <= FILL;
                    end else if (accept && row_last && col_last) begin
                        state      <= FLUSH;
                        in_ready_q <= 1'b0;
                        flush_cnt  <= FW'(IMG_W);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffers hold no reset: stale contents only ever reach border taps.
    always_ff @(posedge clk) begin
        if (a_valid) begin
            lb2[a_col] <= lb1[a_col];
            lb1[a_col] <= a_pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            b_emit   <= 1'b0;
            b_border <= 1'b0;
            b_sof    <= 1'b0;
            b_eof    <= 1'b0;
        end else begin
            b_emit   <= a_valid & a_emit;
            b_border <= a_border;
            b_sof    <= a_valid & a_sof;
            b_eof    <= a_valid & a_eof;
            if (a_valid) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb2[a_col];
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb1[a_col];
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= a_pix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_pix   <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else begin
            bus.out_valid <= b_emit;
            bus.out_sof   <= b_emit & b_sof;
            bus.out_eof   <= b_emit & b_eof;
            if (b_emit) bus.out_pix <= b_border ? win[4] : bus.med_in;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.p0 = win[0];
    assign bus.p1 = win[1];
    assign bus.p2 = win[2];
    assign bus.p3 = win[3];
    assign bus.p4 = win[4];
    assign bus.p5 = win[5];
    assign bus.p6 = win[6];
    assign bus.p7 = win[7];
    assign bus.p8 = win[8];
endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench for median_window_ctrl on a 4x4 image. Supplies the median block
// itself and checks every output against a direct 3x3-neighbourhood model.
module tb_median_window_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int NRUN = N - W - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_window_ctrl_if #(.bit_width(8)) bus ();

    median_window_ctrl #(.bit_width(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [7:0] med9(input logic [71:0] v);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8 - i; k++)
                if (a[k] > a[k+1]) begin t = a[k]; a[k] = a[k+1]; a[k+1] = t; end
        return a[4];
    endfunction

    always_comb bus.med_in = med9({bus.p0, bus.p1, bus.p2, bus.p3, bus.p4,
                                   bus.p5, bus.p6, bus.p7, bus.p8});

    logic [7:0] img [2][N];

    function automatic logic [7:0] ref_px(input int f, input int idx);
        int r, c, k;
        logic [71:0] v;
        r = idx / W;
        c = idx % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return img[f][idx];
        k = 0;
        v = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[k*8 +: 8] = img[f][(r + dr) * W + c + dc];
                k++;
            end
        return med9(v);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         out_cyc_q [$];
    logic [7:0] out_pix_q [$];
    bit         out_sof_q [$];
    bit         out_eof_q [$];
    int         acc_q [$];
    int         rdy_low = 0;
    int         first_low = -1;
    int         stray = 0;
    int         checks = 0;
    int         failures = 0;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            out_cyc_q.push_back(cyc);
            out_pix_q.push_back(bus.out_pix);
            out_sof_q.push_back(bus.out_sof);
            out_eof_q.push_back(bus.out_eof);
        end
        if (bus.out_valid !== 1'b1 && (bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0)) stray++;
        if (bus.in_ready === 1'b0) begin
            if (rdy_low == 0) first_low = cyc;
            rdy_low++;
        end
    end

    task automatic clear_mon();
        out_cyc_q.delete();
        out_pix_q.delete();
        out_sof_q.delete();
        out_eof_q.delete();
        acc_q.delete();
        rdy_low = 0;
        first_low = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Holds the beat until in_ready is seen high, bounded.
    task automatic beat(input logic [7:0] pix, input bit sof);
        int tries = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pix   = pix;
        while (bus.in_ready !== 1'b1 && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (tries >= 20) begin
            checks++; failures++;
            $display("FAIL beat_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int f, input bit gap, input int last);
        for (int i = 0; i <= last; i++) begin
            beat(img[f][i], i == 0);
            if (gap) idle(1);
        end
    endtask

    task automatic fill_random(input int f);
        for (int i = 0; i < N; i++) img[f][i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_pix !== 8'd0) begin failures++; $display("FAIL reset_out_pix: got %0d want 0", bus.out_pix); end
        checks++; if (bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0) begin failures++; $display("FAIL reset_flags: got sof=%b eof=%b want 0", bus.out_sof, bus.out_eof); end
        checks++; if ({bus.p0, bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8} !== 72'h0) begin
            failures++; $display("FAIL reset_taps: got p4=%0d p8=%0d want 0", bus.p4, bus.p8);
        end
        rst = 1'b0;
        clear_mon();
        beat(8'd9, 1'b0);
        idle(6);
        checks++; if (out_pix_q.size() !== 0) begin failures++; $display("FAIL idle_non_sof: got %0d outputs want 0", out_pix_q.size()); end
    endtask

    // constant, ramp, interior impulse, border impulse, two random frames
    task automatic test_frames();
        int expc;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N; i++) begin
                case (p)
                    0: img[0][i] = 8'd7;
                    1: img[0][i] = 8'(i);
                    2: img[0][i] = (i == W + 1) ? 8'd255 : 8'd0;
                    3: img[0][i] = (i == 2) ? 8'd255 : 8'd0;
                    default: img[0][i] = 8'($urandom_range(0, 255));
                endcase
            end
            clear_mon();
            send_frame(0, 1'b0, N - 1);
            idle(12);
            checks++; if (out_pix_q.size() !== N) begin failures++; $display("FAIL frame%0d_count: got %0d want %0d", p, out_pix_q.size(), N); end
            for (int j = 0; j < N && j < out_pix_q.size(); j++) begin
                checks++; if (out_pix_q[j] !== ref_px(0, j)) begin failures++; $display("FAIL frame%0d_pix[%0d]: got %0d want %0d", p, j, out_pix_q[j], ref_px(0, j)); end
                checks++; if (out_sof_q[j] !== (j == 0) || out_eof_q[j] !== (j == N - 1)) begin
                    failures++; $display("FAIL frame%0d_flags[%0d]: got sof=%b eof=%b", p, j, out_sof_q[j], out_eof_q[j]);
                end
                expc = (j < NRUN) ? acc_q[j + W + 1] + 2 : acc_q[N - 1] + 3 + (j - NRUN);
                checks++; if (out_cyc_q[j] !== expc) begin failures++; $display("FAIL frame%0d_latency[%0d]: got cycle %0d want %0d", p, j, out_cyc_q[j], expc); end
            end
            checks++; if (rdy_low !== W + 1) begin failures++; $display("FAIL frame%0d_ready_low: got %0d cycles want %0d", p, rdy_low, W + 1); end
            checks++; if (first_low !== acc_q[N - 1]) begin failures++; $display("FAIL frame%0d_flush_start: got cycle %0d want %0d", p, first_low, acc_q[N - 1]); end
        end
    endtask

    task automatic test_gapped();
        int expc;
        fill_random(0);
        clear_mon();
        send_frame(0, 1'b1, N - 1);
        idle(12);
        checks++; if (out_pix_q.size() !== N) begin failures++; $display("FAIL gap_count: got %0d want %0d", out_pix_q.size(), N); end
        for (int j = 0; j < N && j < out_pix_q.size(); j++) begin
            checks++; if (out_pix_q[j] !== ref_px(0, j)) begin failures++; $display("FAIL gap_pix[%0d]: got %0d want %0d", j, out_pix_q[j], ref_px(0, j)); end
            expc = (j < NRUN) ? acc_q[j + W + 1] + 2 : acc_q[N - 1] + 3 + (j - NRUN);
            checks++; if (out_cyc_q[j] !== expc) begin failures++; $display("FAIL gap_latency[%0d]: got cycle %0d want %0d", j, out_cyc_q[j], expc); end
        end
    endtask

    // sof arrives at index 9: four outputs of frame 0 drain, then a full frame 1
    task automatic test_abort();
        logic [7:0] want;
        for (int i = 0; i < N; i++) begin img[0][i] = 8'd5; img[1][i] = 8'd3; end
        clear_mon();
        send_frame(0, 1'b0, 8);
        send_frame(1, 1'b0, N - 1);
        idle(12);
        checks++; if (out_pix_q.size() !== N + 4) begin failures++; $display("FAIL abort_count: got %0d want %0d", out_pix_q.size(), N + 4); end
        for (int j = 0; j < N + 4 && j < out_pix_q.size(); j++) begin
            want = (j < 4) ? ref_px(0, j) : ref_px(1, j - 4);
            checks++; if (out_pix_q[j] !== want) begin failures++; $display("FAIL abort_pix[%0d]: got %0d want %0d", j, out_pix_q[j], want); end
            checks++; if (out_sof_q[j] !== (j == 0 || j == 4) || out_eof_q[j] !== (j == N + 3)) begin
                failures++; $display("FAIL abort_flags[%0d]: got sof=%b eof=%b", j, out_sof_q[j], out_eof_q[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_random(0);
        clear_mon();
        send_frame(0, 1'b0, 8);
        rst = 1'b1;
        #1;
        clear_mon();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pix !== 8'd0) begin failures++; $display("FAIL rstmid_out: got valid=%b pix=%0d want 0", bus.out_valid, bus.out_pix); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
        checks++; if ({bus.p0, bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8} !== 72'h0) begin
            failures++; $display("FAIL rstmid_taps: got p4=%0d want 0", bus.p4);
        end
        idle(2);
        rst = 1'b0;
        idle(1);
        beat(8'h55, 1'b0);
        idle(10);
        checks++; if (out_pix_q.size() !== 0) begin failures++; $display("FAIL rstmid_no_output: got %0d outputs want 0", out_pix_q.size()); end
        fill_random(0);
        clear_mon();
        send_frame(0, 1'b0, N - 1);
        idle(12);
        checks++; if (out_pix_q.size() !== N) begin failures++; $display("FAIL rstmid_count: got %0d want %0d", out_pix_q.size(), N); end
        for (int j = 0; j < N && j < out_pix_q.size(); j++) begin
            checks++; if (out_pix_q[j] !== ref_px(0, j)) begin failures++; $display("FAIL rstmid_pix[%0d]: got %0d want %0d", j, out_pix_q[j], ref_px(0, j)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        fill_random(0);
        fill_random(1);
        clear_mon();
        send_frame(0, 1'b0, N - 1);
        send_frame(1, 1'b0, N - 1);
        idle(12);
        checks++; if (acc_q[N] !== acc_q[N - 1] + W + 2) begin failures++; $display("FAIL b2b_restart: got cycle %0d want %0d", acc_q[N], acc_q[N - 1] + W + 2); end
        checks++; if (out_pix_q.size() !== 2 * N) begin failures++; $display("FAIL b2b_count: got %0d want %0d", out_pix_q.size(), 2 * N); end
        for (int j = 0; j < 2 * N && j < out_pix_q.size(); j++) begin
            want = (j < N) ? ref_px(0, j) : ref_px(1, j - N);
            checks++; if (out_pix_q[j] !== want) begin failures++; $display("FAIL b2b_pix[%0d]: got %0d want %0d", j, out_pix_q[j], want); end
            checks++; if (out_sof_q[j] !== (j % N == 0) || out_eof_q[j] !== (j % N == N - 1)) begin
                failures++; $display("FAIL b2b_flags[%0d]: got sof=%b eof=%b", j, out_sof_q[j], out_eof_q[j]);
            end
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL flag_without_valid: got %0d cycles want 0", stray); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pix   = 8'd0;
        test_reset();
        test_frames();
        test_gapped();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
